// File: rtl/reg_alias_file.sv
// Architectural register file with per-register rename aliases, fed by the ROB commit port.
// Optional macro REG_COMMIT_BYPASS_EN forwards a matching same-cycle commit onto the read ports.
module reg_alias_file #(
    parameter int REG_NUM  = 32,
    parameter int DATA_W   = 32,
    parameter int ROB_ID_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rollback,
    input  logic [4:0]          rs1_idx,
    input  logic [4:0]          rs2_idx,
    output logic [DATA_W-1:0]   rs1_val,
    output logic                rs1_busy,
    output logic [ROB_ID_W-1:0] rs1_alias,
    output logic [DATA_W-1:0]   rs2_val,
    output logic                rs2_busy,
    output logic [ROB_ID_W-1:0] rs2_alias,
    input  logic                rename_en,
    input  logic [4:0]          rename_rd,
    input  logic [ROB_ID_W-1:0] rename_alias,
    input  logic                commit_en,
    input  logic [4:0]          commit_rd,
    input  logic [DATA_W-1:0]   commit_val,
    input  logic [ROB_ID_W-1:0] commit_alias
);

    logic [DATA_W-1:0]   val_q   [REG_NUM];
    logic [ROB_ID_W-1:0] alias_q [REG_NUM];
    logic                busy_q  [REG_NUM];

    // No handshake: one rename and one commit are accepted every cycle that rdy=1.
    // Entry 0 is never written, so x0 stays at its reset contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i]   <= '0;
                alias_q[i] <= '0;
                busy_q[i]  <= 1'b0;
            end
        end else if (rdy) begin
            for (int i = 1; i < REG_NUM; i++) begin
                if (commit_en && (commit_rd == 5'(i)))
                    val_q[i] <= commit_val;
                // Priority: rollback clears everything, then a rename claims the register,
                // then a commit releases it only if it is still the current owner.
                if (rollback) begin
                    alias_q[i] <= '0;
                    busy_q[i]  <= 1'b0;
                end else if (rename_en && (rename_rd == 5'(i))) begin
                    alias_q[i] <= rename_alias;
                    busy_q[i]  <= 1'b1;
                end else if (commit_en && (commit_rd == 5'(i)) &&
                             (alias_q[i] == commit_alias)) begin
                    alias_q[i] <= '0;
                    busy_q[i]  <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rs1_val   = '0;
        rs1_busy  = 1'b0;
        rs1_alias = '0;
        if (rst && (rs1_idx != 5'd0)) begin
            rs1_val   = val_q[rs1_idx];
            rs1_busy  = busy_q[rs1_idx];
            rs1_alias = alias_q[rs1_idx];
`ifdef REG_COMMIT_BYPASS_EN
            if (rdy && commit_en && (commit_rd == rs1_idx) &&
                (commit_alias == alias_q[rs1_idx])) begin
                rs1_val   = commit_val;
                rs1_busy  = 1'b0;
                rs1_alias = '0;
            end
`endif
        end
    end

    always_comb begin
        rs2_val   = '0;
        rs2_busy  = 1'b0;
        rs2_alias = '0;
        if (rst && (rs2_idx != 5'd0)) begin
            rs2_val   = val_q[rs2_idx];
            rs2_busy  = busy_q[rs2_idx];
            rs2_alias = alias_q[rs2_idx];
`ifdef REG_COMMIT_BYPASS_EN
            if (rdy && commit_en && (commit_rd == rs2_idx) &&
                (commit_alias == alias_q[rs2_idx])) begin
                rs2_val   = commit_val;
                rs2_busy  = 1'b0;
                rs2_alias = '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_reg_alias_file.sv
// Directed, table-driven bench for reg_alias_file, plus hand sequences for bypass and async reset.
module tb_reg_alias_file;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        rollback;
    logic [4:0]  rs1_idx, rs2_idx;
    logic [31:0] rs1_val, rs2_val;
    logic        rs1_busy, rs2_busy;
    logic [3:0]  rs1_alias, rs2_alias;
    logic        rename_en;
    logic [4:0]  rename_rd;
    logic [3:0]  rename_alias;
    logic        commit_en;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val;
    logic [3:0]  commit_alias;

    int checks;
    int failures;

    reg_alias_file dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .rollback     (rollback),
        .rs1_idx      (rs1_idx),
        .rs2_idx      (rs2_idx),
        .rs1_val      (rs1_val),
        .rs1_busy     (rs1_busy),
        .rs1_alias    (rs1_alias),
        .rs2_val      (rs2_val),
        .rs2_busy     (rs2_busy),
        .rs2_alias    (rs2_alias),
        .rename_en    (rename_en),
        .rename_rd    (rename_rd),
        .rename_alias (rename_alias),
        .commit_en    (commit_en),
        .commit_rd    (commit_rd),
        .commit_val   (commit_val),
        .commit_alias (commit_alias)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        rollback;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        ren;
        logic [4:0]  rrd;
        logic [3:0]  ral;
        logic        cen;
        logic [4:0]  crd;
        logic [31:0] cval;
        logic [3:0]  cal;
        logic [31:0] e1v;
        logic        e1b;
        logic [3:0]  e1a;
        logic [31:0] e2v;
        logic        e2b;
        logic [3:0]  e2a;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_port1(input string tag, input logic [31:0] v, input logic b, input logic [3:0] a);
        check({tag, " rs1_val"},   rs1_val,          v);
        check({tag, " rs1_busy"},  32'(rs1_busy),    32'(b));
        check({tag, " rs1_alias"}, 32'(rs1_alias),   32'(a));
    endtask

    task automatic check_port2(input string tag, input logic [31:0] v, input logic b, input logic [3:0] a);
        check({tag, " rs2_val"},   rs2_val,          v);
        check({tag, " rs2_busy"},  32'(rs2_busy),    32'(b));
        check({tag, " rs2_alias"}, 32'(rs2_alias),   32'(a));
    endtask

    task automatic idle_inputs();
        rdy       = 1'b1;
        rollback  = 1'b0;
        rename_en = 1'b0;
        commit_en = 1'b0;
    endtask

    // Drive one vector across a clock edge, then check the registered result with enables dropped.
    task automatic apply_vec(input vec_t v, input int n);
        @(negedge clk);
        rdy          = v.rdy;
        rollback     = v.rollback;
        rs1_idx      = v.rs1;
        rs2_idx      = v.rs2;
        rename_en    = v.ren;
        rename_rd    = v.rrd;
        rename_alias = v.ral;
        commit_en    = v.cen;
        commit_rd    = v.crd;
        commit_val   = v.cval;
        commit_alias = v.cal;
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check_port1($sformatf("vec%0d", n), v.e1v, v.e1b, v.e1a);
        check_port2($sformatf("vec%0d", n), v.e2v, v.e2b, v.e2a);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst          = 1'b0;
        idle_inputs();
        rs1_idx      = 5'd5;
        rs2_idx      = 5'd0;
        rename_rd    = '0;
        rename_alias = '0;
        commit_rd    = '0;
        commit_val   = '0;
        commit_alias = '0;

        //           rdy rb rs1    rs2    ren rrd    ral    cen crd    cval          cal    e1v           e1b e1a    e2v           e2b e2a
        vecs[0]  = '{1, 0, 5'd5,  5'd0, 1, 5'd5,  4'd3, 0, 5'd0,  32'h0,        4'd0, 32'h0,        1, 4'd3, 32'h0,        0, 4'd0};
        vecs[1]  = '{1, 0, 5'd5,  5'd0, 0, 5'd0,  4'd0, 1, 5'd5,  32'hDEADBEEF, 4'd3, 32'hDEADBEEF, 0, 4'd0, 32'h0,        0, 4'd0};
        vecs[2]  = '{1, 0, 5'd7,  5'd5, 1, 5'd7,  4'd2, 0, 5'd0,  32'h0,        4'd0, 32'h0,        1, 4'd2, 32'hDEADBEEF, 0, 4'd0};
        vecs[3]  = '{1, 0, 5'd7,  5'd0, 1, 5'd7,  4'd4, 0, 5'd0,  32'h0,        4'd0, 32'h0,        1, 4'd4, 32'h0,        0, 4'd0};
        vecs[4]  = '{1, 0, 5'd7,  5'd0, 0, 5'd0,  4'd0, 1, 5'd7,  32'h55,       4'd2, 32'h55,       1, 4'd4, 32'h0,        0, 4'd0};
        vecs[5]  = '{1, 0, 5'd7,  5'd0, 0, 5'd0,  4'd0, 1, 5'd7,  32'h77,       4'd4, 32'h77,       0, 4'd0, 32'h0,        0, 4'd0};
        vecs[6]  = '{1, 0, 5'd9,  5'd0, 1, 5'd9,  4'd1, 0, 5'd0,  32'h0,        4'd0, 32'h0,        1, 4'd1, 32'h0,        0, 4'd0};
        vecs[7]  = '{1, 0, 5'd9,  5'd0, 1, 5'd9,  4'd6, 1, 5'd9,  32'h1234,     4'd1, 32'h1234,     1, 4'd6, 32'h0,        0, 4'd0};
        vecs[8]  = '{1, 0, 5'd10, 5'd9, 1, 5'd10, 4'd1, 0, 5'd0,  32'h0,        4'd0, 32'h0,        1, 4'd1, 32'h1234,     1, 4'd6};
        vecs[9]  = '{1, 1, 5'd10, 5'd9, 1, 5'd10, 4'd6, 1, 5'd10, 32'h1234,     4'd1, 32'h1234,     0, 4'd0, 32'h1234,     0, 4'd0};
        vecs[10] = '{1, 0, 5'd0,  5'd0, 1, 5'd0,  4'd5, 1, 5'd0,  32'hFF,       4'd5, 32'h0,        0, 4'd0, 32'h0,        0, 4'd0};
        vecs[11] = '{0, 0, 5'd3,  5'd0, 1, 5'd3,  4'd5, 1, 5'd3,  32'h99,       4'd5, 32'h0,        0, 4'd0, 32'h0,        0, 4'd0};
        vecs[12] = '{1, 0, 5'd3,  5'd0, 1, 5'd3,  4'd5, 0, 5'd0,  32'h0,        4'd0, 32'h0,        1, 4'd5, 32'h0,        0, 4'd0};
        vecs[13] = '{1, 0, 5'd3,  5'd0, 1, 5'd3,  4'd7, 1, 5'd3,  32'h33,       4'd5, 32'h33,       1, 4'd7, 32'h0,        0, 4'd0};
        vecs[14] = '{1, 0, 5'd5,  5'd3, 1, 5'd5,  4'd3, 0, 5'd0,  32'h0,        4'd0, 32'hDEADBEEF, 1, 4'd3, 32'h33,       1, 4'd7};
        vecs[15] = '{1, 0, 5'd5,  5'd3, 0, 5'd0,  4'd0, 1, 5'd5,  32'h11,       4'd1, 32'h11,       1, 4'd3, 32'h33,       1, 4'd7};

        // Held in reset: every read port is zero.
        #2;
        check_port1("in_reset", 32'h0, 1'b0, 4'd0);
        #10;
        rst = 1'b1;
        #1;
        check_port1("after_reset", 32'h0, 1'b0, 4'd0);

        for (int i = 0; i < NVEC; i++)
            apply_vec(vecs[i], i);

        // Same-cycle commit to a busy register: bypass shows it now, otherwise only after the edge.
        apply_vec('{1, 0, 5'd0, 5'd4, 1, 5'd4, 4'd2, 0, 5'd0, 32'h0, 4'd0,
                    32'h0, 0, 4'd0, 32'h0, 1, 4'd2}, 100);
        @(negedge clk);
        rs2_idx      = 5'd4;
        commit_en    = 1'b1;
        commit_rd    = 5'd4;
        commit_val   = 32'hA5;
        commit_alias = 4'd2;
        #1;
`ifdef REG_COMMIT_BYPASS_EN
        check_port2("bypass_same_cycle", 32'hA5, 1'b0, 4'd0);
`else
        check_port2("no_bypass_same_cycle", 32'h0, 1'b1, 4'd2);
`endif
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check_port2("bypass_after_edge", 32'hA5, 1'b0, 4'd0);

        // Asynchronous reset mid-cycle with x5 busy (alias 3, value 0x11).
        @(negedge clk);
        rs1_idx = 5'd5;
        rs2_idx = 5'd7;
        #1;
        check_port1("pre_reset_x5", 32'h11, 1'b1, 4'd3);
        rst = 1'b0;
        #1;
        check_port1("async_reset_x5", 32'h0, 1'b0, 4'd0);
        check_port2("async_reset_x7", 32'h0, 1'b0, 4'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_port1("post_reset_x5", 32'h0, 1'b0, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_alias_file.md
Name: reg_alias_file

Overview:
- Architectural register file with per-register rename tags, located directly downstream of the reorder buffer's commit port.
- The dispatcher reads operand values and rename aliases from it and writes the destination alias of each dispatched instruction.
- The ROB commit port writes retired results into it and clears the busy state of the register.
- A rollback clears every outstanding alias, so all registers fall back to their committed values.

Parameters:
- REG_NUM, 32, number of architectural registers (x0..x31).
- DATA_W, 32, register data width.
- ROB_ID_W, 4, alias width. Alias 0 means "no alias". Valid ROB ids are 1..2^ROB_ID_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low. Asserted when 0.
- rdy  input  1  global run enable. When 0, the block is paused.
- rollback  input  1  mispredict flush from ROB.
- rs1_idx  input  5  dispatcher query, source register 1.
- rs2_idx  input  5  dispatcher query, source register 2.
- rs1_val  output  DATA_W  committed value of rs1.
- rs1_busy  output  1  rs1 has an outstanding alias.
- rs1_alias  output  ROB_ID_W  ROB id producing rs1. 0 when not busy.
- rs2_val  output  DATA_W  same meaning as rs1_val, for rs2.
- rs2_busy  output  1  same meaning as rs1_busy, for rs2.
- rs2_alias  output  ROB_ID_W  same meaning as rs1_alias, for rs2.
- rename_en  input  1  dispatcher allocates an alias for a destination register.
- rename_rd  input  5  destination register to rename.
- rename_alias  input  ROB_ID_W  ROB id allocated to that destination.
- commit_en  input  1  ROB retires a register-writing instruction.
- commit_rd  input  5  register written by the retiring instruction.
- commit_val  input  DATA_W  retired result.
- commit_alias  input  ROB_ID_W  ROB id of the retiring instruction.

Behaviour:
- Storage: val[REG_NUM], alias[REG_NUM], busy[REG_NUM].
- Asynchronous reset (rst=0): all val=0, alias=0, busy=0, applied immediately with no clock edge required.
- Read outputs are combinational from stored state.
  - Within one cycle, a rename or commit is not visible on the read outputs until after the edge. This ensures an instruction never observes its own rename.
  - With rst=0, all read outputs are 0.
- x0 handling:
  - rename or commit targeting x0 is ignored.
  - Reads of x0 always return val=0, busy=0, alias=0.
- rdy=0: no state changes, regardless of the other inputs. Reads remain valid.
- Commit (rdy=1, commit_en=1, commit_rd!=0):
  - val[commit_rd] <= commit_val, unconditionally.
  - If alias[commit_rd]==commit_alias and no same-cycle rename of commit_rd: busy<=0 and alias<=0.
  - If the aliases do not match, a younger writer owns the register and busy/alias are unchanged.
- Rename (rdy=1, rename_en=1, rename_rd!=0, rollback=0): alias[rename_rd] <= rename_alias and busy <= 1.
- Rename and commit to the same register in the same cycle: the commit value is written, and the rename sets busy/alias. Rename wins regardless of alias match.
- Rollback (rdy=1, rollback=1):
  - All busy <= 0 and all alias <= 0.
  - A same-cycle rename is dropped.
  - A same-cycle commit still writes its value.
- Single-cycle latency for all updates.
- No backpressure. The block always accepts one rename and one commit per cycle.

Optional Feature:
- Macro: REG_COMMIT_BYPASS_EN.
- Defined: the read path forwards a same-cycle commit.
  - Condition: commit_en=1, commit_rd==rsX_idx!=0, and commit_alias==alias[rsX_idx].
  - Effect: rsX_val=commit_val, rsX_busy=0, rsX_alias=0 in that cycle.
  - Forwarding is gated by rdy=1 and rst=1.
- Undefined: reads strictly reflect registered state. A commit becomes visible one cycle later.

Test Plan:
- Reset: drive rst=0 mid-run with x5 busy (alias 3, value 0x11).
  - Required: immediately x5 reads val=0, busy=0, alias=0, with no clock edge.
- Rename then matching commit:
  - Rename x5 with alias 3, then read rs1_idx=5. Required: busy=1, alias=3.
  - Commit x5, value 0xDEADBEEF, alias 3. Required next cycle: val=0xDEADBEEF, busy=0, alias=0.
- Stale commit:
  - Rename x7 with alias 2, then rename x7 with alias 4.
  - Commit x7, value 0x55, alias 2. Required: val=0x55, busy=1, alias=4.
  - Commit x7, alias 4. Required: busy=0.
- Simultaneous events:
  - Same cycle: rename x9 with alias 6 and commit x9, value 0x1234, with matching old alias 1. Required: val=0x1234, busy=1, alias=6.
  - With rollback=1 in the same cycle instead: required busy=0, alias=0, val=0x1234.
- x0 and pause:
  - rename and commit x0 with value 0xFF. Required: x0 reads 0, not busy.
  - With rdy=0, rename x3 with alias 5. Required: x3 unchanged.
- Bypass (macro defined): x4 busy with alias 2, commit x4, value 0xA5, alias 2, and read rs2_idx=4 in the same cycle.
  - Required: rs2_val=0xA5, rs2_busy=0 combinationally.
  - With the macro undefined: rs2_busy=1 that cycle, and 0xA5 is visible only after the edge.
